// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
//   Memory-mapped 8N1 UART transmitter sitting on the data-memory bus.
//   Stores to TXDATA push bytes into a small FIFO; the serializer drains the
//   FIFO onto tx at a programmable number of clock cycles per bit.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst      : asynchronous active-low reset
//   cs       : block select (this block's 16-byte window)
//   wr       : 1 = store, 0 = load (qualified by cs)
//   mask     : byte-lane enables for stores
//   addr     : byte address, only addr[3:2] decoded
//   data_wr  : store data
//   data_rd  : load data (combinational), 0 when not a load to this block
//   tx       : serial output, idles high, registered
//   tx_busy  : high while a frame is on the line
//
// Register map (addr[3:2])
//   0 TXDATA  (W)   push data_wr[7:0] when mask[0]
//   1 STATUS  (R/W) [0] empty [1] full [2] busy [3] overflow (write 1 to clear)
//   2 BAUDDIV (R/W) [15:0] cycles per bit, 0 is stored as 1
//   3 CTRL    (R/W) [0] enable
module uart_tx_mmio #(
    parameter int          DEPTH       = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        tx,
    output logic        tx_busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and pointers (one extra MSB distinguishes full from empty)
    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        r_ovf;

    // Programmable registers
    logic [15:0] r_baud;
    logic        r_enable;

    // Serializer state
    state_t      r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_div;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        r_busy;

    logic        w_empty;
    logic        w_full;
    logic        w_store;
    logic [1:0]  w_sel;
    logic        w_push_req;
    logic        w_push;
    logic        w_ovf_set;
    logic        w_ovf_clr;
    logic        w_bit_end;
    logic        w_pop;
    logic [7:0]  w_head;
    logic [15:0] w_baud_mod;
    logic [15:0] w_baud_next;
    logic        w_unused;

    assign w_unused = ^{addr[31:4], addr[1:0], data_wr[31:16]};

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    assign w_store    = cs && wr;
    assign w_sel      = addr[3:2];
    assign w_push_req = w_store && (w_sel == 2'd0) && mask[0];
    // Fullness is judged before any same-cycle pop: a pop never makes room
    // for a push arriving on the same edge.
    assign w_push     = w_push_req && !w_full;
    assign w_ovf_set  = w_push_req && w_full;
    assign w_ovf_clr  = w_store && (w_sel == 2'd1) && mask[0] && data_wr[3];

    assign w_bit_end = (r_cnt == (r_div - 16'd1));
    // Pop either from IDLE or at the very end of a stop bit (back-to-back).
    assign w_pop = r_enable && !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
    assign w_head = r_mem[r_rptr[AW-1:0]];

    assign w_baud_mod  = {mask[1] ? data_wr[15:8] : r_baud[15:8],
                          mask[0] ? data_wr[7:0]  : r_baud[7:0]};
    assign w_baud_next = (w_baud_mod == 16'd0) ? 16'd1 : w_baud_mod;

    // FIFO storage has no reset; emptiness is carried by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= data_wr[7:0];
        end
    end

    // FIFO pointers, overflow flag and bus-writable registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_ovf    <= 1'b0;
            r_baud   <= DEFAULT_DIV;
            r_enable <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_store && (w_sel == 2'd2)) begin
                r_baud <= w_baud_next;
            end
            if (w_store && (w_sel == 2'd3) && mask[0]) begin
                r_enable <= data_wr[0];
            end
        end
    end

    // Serializer FSM. The frame divisor is latched at each pop so a BAUDDIV
    // write mid-frame only affects the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_div     <= DEFAULT_DIV;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_tx  <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_div   <= r_baud;
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            // next bit is the one that lands in shift[0]
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_div   <= r_baud;
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;

    // Load path: only a load (cs && !wr) returns register contents.
    always_comb begin
        data_rd = 32'd0;
        if (cs && !wr) begin
            case (w_sel)
                2'd1:    data_rd = {28'd0, r_ovf, r_busy, w_full, w_empty};
                2'd2:    data_rd = {16'd0, r_baud};
                2'd3:    data_rd = {31'd0, r_enable};
                default: data_rd = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed testbench for uart_tx_mmio: register access, frame shape,
// back-to-back frames, FIFO overflow, BAUDDIV lanes and mid-frame reset.
module tb_uart_tx_mmio;

    logic        clk;
    logic        rst;
    logic        cs;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        tx;
    logic        tx_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // expected tx pattern per frame, bit k = line level during bit period k
    logic [9:0] exp_pat [3];

    uart_tx_mmio #(
        .DEPTH      (8),
        .DEFAULT_DIV(16'd868)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cs     (cs),
        .wr     (wr),
        .mask   (mask),
        .addr   (addr),
        .data_wr(data_wr),
        .data_rd(data_rd),
        .tx     (tx),
        .tx_busy(tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Store: takes effect at the rising edge following the setup negedge.
    task automatic bus_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        cs      = 1'b1;
        wr      = 1'b1;
        addr    = a;
        data_wr = d;
        mask    = m;
        @(posedge clk);
        #1;
        cs      = 1'b0;
        wr      = 1'b0;
        mask    = 4'h0;
        $display("[TB] store addr=0x%0h data=0x%0h mask=0x%0h", a, d, m);
    endtask

    task automatic bus_load(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        cs   = 1'b1;
        wr   = 1'b0;
        addr = a;
        #1;
        v    = data_rd;
        #1;
        cs   = 1'b0;
        $display("[TB] load  addr=0x%0h data=0x%0h", a, v);
    endtask

    // Called right after the store edge that starts transmission: the pop
    // happens at the next edge, tx falls after it. Samples each bit in its
    // middle and counts busy cycles over a window wider than the frames.
    task automatic expect_frames(input int div, input int nfr);
        int busy_cnt;
        int span;
        int rel;
        int f;
        int k;
        logic [9:0] pat;
        busy_cnt = 0;
        span     = nfr * 10 * div;
        for (int j = 0; j < span + 2 * div + 4; j++) begin
            @(negedge clk);
            if (tx_busy) busy_cnt++;
            if (j >= 1 && j < 1 + span) begin
                rel = j - 1;
                if ((rel % div) == (div / 2)) begin
                    f   = rel / (10 * div);
                    k   = (rel % (10 * div)) / div;
                    pat = exp_pat[f];
                    check($sformatf("tx_f%0d_b%0d", f, k), {31'd0, tx}, {31'd0, pat[k]});
                end
            end
        end
        check("busy_cycles", busy_cnt, span);
        check("tx_idle_after", {31'd0, tx}, 32'd1);
        $display("[TB] %0d frame(s) at div=%0d observed, busy=%0d", nfr, div, busy_cnt);
    endtask

    initial begin
        logic [31:0] v;
        rst     = 1'b0;
        cs      = 1'b0;
        wr      = 1'b0;
        mask    = 4'h0;
        addr    = 32'd0;
        data_wr = 32'd0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        rst = 1'b1;
        bus_load(32'h4, v); check("rst_status", v, 32'h1);
        bus_load(32'h8, v); check("rst_baud", v, 32'd868);
        bus_load(32'hC, v); check("rst_ctrl", v, 32'd0);
        bus_load(32'h0, v); check("txdata_reads0", v, 32'd0);

        // ---- single frame 0xA5 at div 4 ----
        bus_store(32'h8, 32'd4, 4'h3);
        bus_store(32'hC, 32'd1, 4'h1);
        exp_pat[0] = {1'b1, 8'hA5, 1'b0};
        bus_store(32'h0, 32'hA5, 4'h1);
        expect_frames(4, 1);
        bus_load(32'h4, v); check("a5_status_end", v, 32'h1);

        // ---- three back-to-back frames at div 2 ----
        bus_store(32'hC, 32'd0, 4'h1);
        bus_store(32'h8, 32'd2, 4'h3);
        bus_store(32'h0, 32'h01, 4'h1);
        bus_store(32'h0, 32'h02, 4'h1);
        bus_store(32'h0, 32'h03, 4'h1);
        bus_load(32'h4, v); check("b2b_status_pending", v, 32'h0);
        exp_pat[0] = {1'b1, 8'h01, 1'b0};
        exp_pat[1] = {1'b1, 8'h02, 1'b0};
        exp_pat[2] = {1'b1, 8'h03, 1'b0};
        bus_store(32'hC, 32'd1, 4'h1);
        expect_frames(2, 3);
        bus_load(32'h4, v); check("b2b_status_end", v, 32'h1);

        // ---- overflow: 9 pushes into 8 entries while disabled ----
        bus_store(32'hC, 32'd0, 4'h1);
        for (int i = 0; i < 9; i++) begin
            bus_store(32'h0, 32'h10 + i, 4'h1);
        end
        bus_load(32'h4, v); check("ovf_status", v, 32'hA);
        bus_store(32'h4, 32'h8, 4'h1);
        bus_load(32'h4, v); check("ovf_cleared", v, 32'h2);

        // ---- BAUDDIV lanes and zero clamp ----
        bus_store(32'h8, 32'h0, 4'h3);
        bus_load(32'h8, v); check("baud_zero_clamp", v, 32'h1);
        bus_store(32'h8, 32'h1234, 4'h1);
        bus_load(32'h8, v); check("baud_lane0", v, 32'h34);
        bus_store(32'h8, 32'hAB00, 4'h2);
        bus_load(32'h8, v); check("baud_lane1", v, 32'hAB34);

        // ---- mid-frame reset ----
        bus_store(32'h8, 32'd2, 4'h3);
        bus_store(32'hC, 32'd1, 4'h1);
        repeat (7) @(negedge clk);
        check("mid_busy", {31'd0, tx_busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_tx", {31'd0, tx}, 32'd1);
        check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus_load(32'h4, v); check("post_rst_status", v, 32'h1);
        bus_load(32'h8, v); check("post_rst_baud", v, 32'd868);
        bus_load(32'hC, v); check("post_rst_ctrl", v, 32'd0);

        // ---- clean frame after reset ----
        bus_store(32'h8, 32'd3, 4'h3);
        bus_store(32'hC, 32'd1, 4'h1);
        exp_pat[0] = {1'b1, 8'h3C, 1'b0};
        bus_store(32'h0, 32'h3C, 4'h1);
        expect_frames(3, 1);
        bus_load(32'h4, v); check("final_status", v, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
